wb_host_master: RTL and testbench
=================================

# wb_host_master

Single-outstanding Wishbone classic-cycle initiator: converts one request from a simple valid/ready command port into one Wishbone read or write, waits for `ack_i` and returns the read data or an error on a valid/ready response port. It sits between a host-side sequencer and memory-mapped peripherals such as the coprocessor slave, whose registered single-cycle `ack_o` it is designed to drive. An optional watchdog aborts cycles that are never acknowledged.

## Interface
- `ADR_W`, 5: Wishbone address width.
- `TIMEOUT`, 16: cycles with `cyc_o` high and no `ack_i` before abort. Legal range 1..255.
- `clk` input 1: clock; all logic on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req_valid_i` input 1: host request valid.
- `req_ready_o` output 1: request accepted when high together with `req_valid_i`.
- `req_we_i` input 1: 1 = write, 0 = read.
- `req_adr_i` input ADR_W: target address.
- `req_dat_i` input 32: write data (ignored for reads).
- `rsp_valid_o` output 1: response valid.
- `rsp_ready_i` input 1: host consumes the response.
- `rsp_dat_o` output 32: read data; 0 for writes and errors.
- `rsp_err_o` output 1: 1 = cycle aborted by the watchdog.
- `adr_o` output ADR_W, `dat_o` output 32, `we_o` output 1, `stb_o` output 1, `cyc_o` output 1: Wishbone initiator outputs, all registered.
- `dat_i` input 32, `ack_i` input 1: Wishbone responder inputs.

## Operation
- FSM states: IDLE, BUS, RSP. Reset state IDLE.
- IDLE: `req_ready_o` = 1, decoded from state only. On `req_valid_i` the request is latched into `adr_o`/`dat_o`/`we_o`, `cyc_o` and `stb_o` are set to 1 and the FSM moves to BUS. The watchdog counter is cleared.
- BUS: `cyc_o` = `stb_o` = 1 and the address/data/we outputs are stable. `req_ready_o` = 0.
  - On `ack_i` the FSM clears `cyc_o`/`stb_o` on the same edge. `rsp_dat_o` takes `dat_i` for a read and 0 for a write, `rsp_err_o` takes 0, and the FSM moves to RSP.
  - When there is no `ack_i`, the counter increments.
- RSP: `rsp_valid_o` = 1, and `rsp_dat_o`/`rsp_err_o` are held stable until `rsp_ready_i` = 1. The FSM then moves to IDLE. `ack_i` is ignored in IDLE and RSP.
- `cyc_o` and `stb_o` are always equal, with one transfer per cycle and no bursts or pipelining.
- `dat_o` keeps its last value after a cycle ends, and `we_o` is cleared with `cyc_o`.

## Timing
- Reset values: `req_ready_o` 1 (IDLE); `rsp_valid_o`, `rsp_err_o`, `cyc_o`, `stb_o`, `we_o` 0; `rsp_dat_o`, `dat_o`, `adr_o` 0.
- Request accepted at edge E0:
  - `cyc_o`/`stb_o` are high from E0.
  - A registered responder raises `ack_i` after E1.
  - The initiator samples it at E2, so `rsp_valid_o` is high after E2.
  - The strobe lasts exactly two cycles and latency is 3 cycles.
- Back-to-back requests with `rsp_ready_i` held high give one transaction per 4 cycles.
- The initiator drops `stb_o` on the edge where it samples `ack_i`. The responder therefore never sees a second strobe.
- Reset asserted mid-operation: all outputs take their reset values immediately, and any cycle in flight is abandoned with no response.

## Configuration
- `WB_HOST_TIMEOUT_EN` defined: watchdog present.
  - In BUS, when the counter reaches `TIMEOUT` with `ack_i` low, `cyc_o`/`stb_o`/`we_o` clear and `rsp_err_o` = 1, `rsp_dat_o` = 0, and the FSM moves to RSP.
  - If `ack_i` is high on the edge where the counter reaches `TIMEOUT`, the acknowledge wins and the cycle completes normally with `rsp_err_o` = 0.
- Not defined: no counter logic, `rsp_err_o` is tied to 0, and BUS waits for `ack_i` indefinitely.

## Test plan
- Write 0xDEADBEEF to 0x04 against a registered responder:
  - `cyc_o`/`stb_o`/`we_o` high for 2 cycles, `adr_o` = 0x04, `dat_o` = 0xDEADBEEF.
  - `rsp_valid_o` high 3 cycles after acceptance, `rsp_dat_o` = 0, `rsp_err_o` = 0.
- Read 0x0C with the responder returning 0x12345678 -> `we_o` = 0, `rsp_dat_o` = 0x12345678, `rsp_err_o` = 0.
- `rsp_ready_i` held low for 5 cycles after a response, with `req_valid_i` high throughout:
  - `rsp_valid_o`/`rsp_dat_o` stay stable, `req_ready_o` = 0, and no second strobe is issued.
  - The next request is accepted one cycle after `rsp_ready_i` rises.
- With `WB_HOST_TIMEOUT_EN` and no responder, read 0x10:
  - `cyc_o` drops after 16 cycles.
  - `rsp_err_o` = 1, `rsp_dat_o` = 0.
- With `WB_HOST_TIMEOUT_EN`, `ack_i` with `dat_i` = 0xA5A5A5A5 arrives on the edge where the counter reaches 16 -> `rsp_err_o` = 0, `rsp_dat_o` = 0xA5A5A5A5.
- `rst_n` pulsed low while in BUS:
  - `cyc_o`/`stb_o` go to 0 asynchronously, before the next clock edge, and `rsp_valid_o` is never raised.
  - After release, `req_ready_o` = 1 and a new write completes normally.

Source files
------------

// File: rtl/wb_host_master.sv
// Single-outstanding Wishbone classic initiator behind a valid/ready port.
// Define WB_HOST_TIMEOUT_EN to add the unacknowledged-cycle watchdog.
module wb_host_master #(
  parameter int ADR_W   = 5,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [ADR_W-1:0] req_adr_i,
  input  logic [31:0]      req_dat_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_dat_o,
  output logic             rsp_err_o,
  output logic [ADR_W-1:0] adr_o,
  output logic [31:0]      dat_o,
  output logic             we_o,
  output logic             stb_o,
  output logic             cyc_o,
  input  logic [31:0]      dat_i,
  input  logic             ack_i
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RSP
  } state_t;

  state_t state;
  logic   wd_hit;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("wb_host_master: TIMEOUT out of range 1..255");
  end

  assign req_ready_o = (state == IDLE);
  assign rsp_valid_o = (state == RSP);

`ifdef WB_HOST_TIMEOUT_EN
  logic [7:0] wd_cnt;
  logic       rsp_err_q;

  // wd_hit fires on the edge the count would reach TIMEOUT
  assign wd_hit    = (wd_cnt == 8'(TIMEOUT - 1));
  assign rsp_err_o = rsp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt    <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid_i) wd_cnt <= '0;
        end
        BUS: begin
          if (ack_i) begin
            rsp_err_q <= 1'b0;
          end else if (wd_hit) begin
            rsp_err_q <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign wd_hit    = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      adr_o     <= '0;
      dat_o     <= '0;
      we_o      <= 1'b0;
      stb_o     <= 1'b0;
      cyc_o     <= 1'b0;
      rsp_dat_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid_i) begin
            adr_o <= req_adr_i;
            dat_o <= req_dat_i;
            we_o  <= req_we_i;
            stb_o <= 1'b1;
            cyc_o <= 1'b1;
            state <= BUS;
          end
        end
        BUS: begin
          if (ack_i) begin
            stb_o     <= 1'b0;
            cyc_o     <= 1'b0;
            we_o      <= 1'b0;
            rsp_dat_o <= we_o ? 32'h0 : dat_i;
            state     <= RSP;
          end else if (wd_hit) begin
            stb_o     <= 1'b0;
            cyc_o     <= 1'b0;
            we_o      <= 1'b0;
            rsp_dat_o <= 32'h0;
            state     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_host_master.sv
// Scoreboard bench for wb_host_master with a registered Wishbone responder.
// Define WB_HOST_TIMEOUT_EN to also exercise the watchdog.
module tb_wb_host_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [4:0]  req_adr_i = '0;
  logic [31:0] req_dat_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic [4:0]  adr_o;
  logic [31:0] dat_o;
  logic        we_o;
  logic        stb_o;
  logic        cyc_o;
  logic [31:0] dat_i = '0;
  logic        ack_i = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;

  // responder mode: 0 silent, 1 registered ack, 2 ack on 16th strobe cycle
  int          mode = 1;
  logic [31:0] rd_data = '0;
  int          bus_cyc = 0;

  logic [31:0] exp_dat_q[$];
  logic        exp_err_q[$];

  wb_host_master #(
    .ADR_W  (5),
    .TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_we_i   (req_we_i),
    .req_adr_i  (req_adr_i),
    .req_dat_i  (req_dat_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_dat_o  (rsp_dat_o),
    .rsp_err_o  (rsp_err_o),
    .adr_o      (adr_o),
    .dat_o      (dat_o),
    .we_o       (we_o),
    .stb_o      (stb_o),
    .cyc_o      (cyc_o),
    .dat_i      (dat_i),
    .ack_i      (ack_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(posedge clk) begin
    bus_cyc <= cyc_o ? bus_cyc + 1 : 0;
    if (mode == 1) begin
      ack_i <= cyc_o & stb_o & ~ack_i;
      dat_i <= (cyc_o & stb_o & ~ack_i & ~we_o) ? rd_data : 32'h0;
    end else if (mode == 2) begin
      ack_i <= cyc_o && (bus_cyc == 14);
      dat_i <= 32'hA5A5A5A5;
    end else begin
      ack_i <= 1'b0;
      dat_i <= 32'h0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // scoreboard monitor: compares each response as it is consumed
  always @(negedge clk) begin
    if (rst_n && rsp_valid_o && rsp_ready_i) begin
      if (exp_dat_q.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid_o), 32'h0);
      end else begin
        chk("rsp_dat", rsp_dat_o, exp_dat_q.pop_front());
        chk("rsp_err", 32'(rsp_err_o), 32'(exp_err_q.pop_front()));
      end
    end
  end

  task automatic wait_ready(input string nm);
    int k = 0;
    @(negedge clk);
    while (!req_ready_o && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready_o) chk({nm, "_ready_timeout"}, 32'(req_ready_o), 32'h1);
  endtask

  task automatic wait_rsp(input string nm);
    int k = 0;
    while (!rsp_valid_o && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!rsp_valid_o) chk({nm, "_rsp_timeout"}, 32'(rsp_valid_o), 32'h1);
  endtask

  task automatic xfer(input string nm, input logic we,
                      input logic [4:0] adr, input logic [31:0] dat,
                      input logic [31:0] edat, input logic eerr,
                      input int stb_len);
    int n;
    int sc;
    wait_ready(nm);
    req_we_i    = we;
    req_adr_i   = adr;
    req_dat_i   = dat;
    req_valid_i = 1'b1;
    exp_dat_q.push_back(edat);
    exp_err_q.push_back(eerr);
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    @(negedge clk);
    chk({nm, "_adr"}, 32'(adr_o), 32'(adr));
    chk({nm, "_we"}, 32'(we_o), 32'(we));
    chk({nm, "_cyc_stb"}, {30'h0, cyc_o, stb_o}, 32'h3);
    if (we) chk({nm, "_dat_o"}, dat_o, dat);
    n  = 1;
    sc = 1;
    while (!rsp_valid_o && n < 60) begin
      @(negedge clk);
      n++;
      if (cyc_o) sc++;
    end
    chk({nm, "_latency"}, 32'(n), 32'(stb_len + 1));
    chk({nm, "_stb_len"}, 32'(sc), 32'(stb_len));
  endtask

  initial begin
    int t0;
    int acc[$];
    bit bad;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready_o), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err_o), 32'h0);
    chk("rst_rsp_dat", rsp_dat_o, 32'h0);
    chk("rst_wb_ctl", {29'h0, cyc_o, stb_o, we_o}, 32'h0);
    chk("rst_adr", 32'(adr_o), 32'h0);
    chk("rst_dat_o", dat_o, 32'h0);
    rst_n = 1'b1;

    xfer("wr04", 1'b1, 5'h04, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    @(negedge clk);
    chk("dat_o_hold", dat_o, 32'hDEADBEEF);

    rd_data = 32'h12345678;
    xfer("rd0c", 1'b0, 5'h0C, 32'hFFFFFFFF, 32'h12345678, 1'b0, 2);

    // back-to-back writes with rsp_ready held high
    wait_ready("b2b");
    req_we_i    = 1'b1;
    req_adr_i   = 5'h08;
    req_dat_i   = 32'h11111111;
    req_valid_i = 1'b1;
    repeat (3) begin
      exp_dat_q.push_back(32'h0);
      exp_err_q.push_back(1'b0);
    end
    t0 = 0;
    while (acc.size() < 3 && t0 < 40) begin
      if (req_valid_i && req_ready_o) acc.push_back(cyc_n);
      if (acc.size() < 3) @(negedge clk);
      t0++;
    end
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    chk("b2b_count", 32'(acc.size()), 32'd3);
    if (acc.size() == 3) begin
      chk("b2b_gap1", 32'(acc[1] - acc[0]), 32'd4);
      chk("b2b_gap2", 32'(acc[2] - acc[1]), 32'd4);
    end

    // response stall with a second request pending
    rd_data = 32'h0BADF00D;
    wait_ready("stall");
    rsp_ready_i = 1'b0;
    req_we_i    = 1'b0;
    req_adr_i   = 5'h14;
    req_valid_i = 1'b1;
    exp_dat_q.push_back(32'h0BADF00D);
    exp_err_q.push_back(1'b0);
    @(posedge clk);
    #1;
    req_we_i  = 1'b1;
    req_adr_i = 5'h1C;
    req_dat_i = 32'h55AA55AA;
    exp_dat_q.push_back(32'h0);
    exp_err_q.push_back(1'b0);
    @(negedge clk);
    wait_rsp("stall");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_valid", 32'(rsp_valid_o), 32'h1);
      chk("stall_dat", rsp_dat_o, 32'h0BADF00D);
      chk("stall_ready", 32'(req_ready_o), 32'h0);
      chk("stall_cyc", 32'(cyc_o), 32'h0);
    end
    @(posedge clk);
    #1 rsp_ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stall_next_accept", 32'(req_ready_o && req_valid_i), 32'h1);
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    @(negedge clk);
    chk("stall_next_adr", 32'(adr_o), 32'h1C);
    chk("stall_next_we", 32'(we_o), 32'h1);
    wait_rsp("stall_next");

`ifdef WB_HOST_TIMEOUT_EN
    mode = 0;
    xfer("wd_rd10", 1'b0, 5'h10, 32'h0, 32'h0, 1'b1, 16);
    mode = 2;
    xfer("wd_ackwin", 1'b0, 5'h18, 32'h0, 32'hA5A5A5A5, 1'b0, 16);
    mode = 1;
`endif

    // asynchronous reset while a cycle is in flight
    wait_ready("rst");
    req_we_i    = 1'b1;
    req_adr_i   = 5'h1E;
    req_dat_i   = 32'hCAFEF00D;
    req_valid_i = 1'b1;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    @(negedge clk);
    chk("rst_mid_cyc_pre", 32'(cyc_o), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc_stb", {30'h0, cyc_o, stb_o}, 32'h0);
    chk("rst_mid_adr", 32'(adr_o), 32'h0);
    chk("rst_mid_ready", 32'(req_ready_o), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid_o) bad = 1'b1;
    end
    chk("rst_no_rsp", 32'(bad), 32'h0);
    xfer("wr_after_rst", 1'b1, 5'h04, 32'h01020304, 32'h0, 1'b0, 2);

    t0 = 0;
    while (exp_dat_q.size() != 0 && t0 < 60) begin
      @(negedge clk);
      t0++;
    end
    @(negedge clk);
    chk("queue_drained", 32'(exp_dat_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
